// File: rtl/tile_skew_feeder.sv
// Pops one SIZE x SIZE tile from the tile FIFO and replays it as a diagonally skewed
// stream of SIZE-lane beats (2*SIZE-1 beats per tile) under valid/ready handshake.
module tile_skew_feeder #(
    parameter int BITS = 8,
    parameter int SIZE = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic                                  fifo_pop,
    input  logic                                  fifo_pop_rdy,
    input  logic [SIZE-1:0][SIZE-1:0][BITS-1:0]   fifo_dout,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SIZE-1:0][BITS-1:0]             out_data,
    output logic [SIZE-1:0]                       out_lane_vld,
    output logic                                  out_first,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int STEPS = 2 * SIZE - 1;
    localparam int LAST  = STEPS - 1;
    localparam int TW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int DW    = $clog2(2 * SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } state_e;

    state_e                              state_q, state_d;
    logic [TW-1:0]                       t_q, t_d;
    logic [SIZE-1:0][SIZE-1:0][BITS-1:0] tile_q, tile_d;

    logic                   streaming;
    logic                   is_last;
    logic                   pop_req;
    logic signed [DW-1:0]   diff;

    assign streaming = (state_q == STREAM);
    assign is_last   = (t_q == TW'(LAST));

    // The pop is gated by rst_n so a held reset never advances the FIFO head.
    assign fifo_pop  = pop_req & rst_n;
    assign out_valid = streaming;
    assign out_first = streaming & (t_q == '0);
    assign out_last  = streaming & is_last;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        tile_d  = tile_q;
        pop_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_pop_rdy) begin
                    pop_req = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                tile_d  = fifo_dout;
                t_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    if (is_last) begin
                        pop_req = fifo_pop_rdy;
                        state_d = fifo_pop_rdy ? FETCH : IDLE;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane i carries column t-i of row i; signed difference keeps out-of-range steps from wrapping in.
    always_comb begin
        out_data     = '0;
        out_lane_vld = '0;
        diff         = '0;
        for (int i = 0; i < SIZE; i++) begin
            diff = $signed(DW'(t_q)) - $signed(DW'(i));
            for (int j = 0; j < SIZE; j++) begin
                if (streaming && (diff == $signed(DW'(j)))) begin
                    out_data[i]     = tile_q[i][j];
                    out_lane_vld[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            tile_q  <= tile_d;
        end
    end

endmodule

// File: tb/tb_tile_skew_feeder.sv
// Randomized bench: a queue-based FIFO and beat-list reference model checked every cycle.
module tb_tile_skew_feeder;

    localparam int BITS = 8;
    localparam int SIZE = 2;
    localparam int NB   = 2 * SIZE - 1;

    typedef logic [SIZE-1:0][SIZE-1:0][BITS-1:0] tile_t;
    typedef struct packed {
        logic [SIZE-1:0][BITS-1:0] dat;
        logic [SIZE-1:0]           vld;
        logic                      first;
        logic                      last;
    } beat_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      fifo_pop;
    logic                      fifo_pop_rdy = 1'b0;
    tile_t                     fifo_dout = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [SIZE-1:0][BITS-1:0] out_data;
    logic [SIZE-1:0]           out_lane_vld;
    logic                      out_first;
    logic                      out_last;
    logic                      busy;

    tile_skew_feeder #(.BITS(BITS), .SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_pop     (fifo_pop),
        .fifo_pop_rdy (fifo_pop_rdy),
        .fifo_dout    (fifo_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_lane_vld (out_lane_vld),
        .out_first    (out_first),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    tile_t fifo_q[$];
    beat_t exp_q[$];
    bit    fetch_wait = 1'b0;
    bit    pend_dout  = 1'b0;
    tile_t pend_tile  = '0;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Beat k of a tile: lane i shows element [i][k-i] when that column exists.
    function automatic beat_t make_beat(input tile_t t, input int k);
        beat_t b;
        b = '0;
        for (int i = 0; i < SIZE; i++) begin
            int c;
            c = k - i;
            if (c >= 0 && c < SIZE) begin
                b.dat[i] = t[i][c];
                b.vld[i] = 1'b1;
            end
        end
        b.first = (k == 0);
        b.last  = (k == NB - 1);
        return b;
    endfunction

    task automatic step(input bit rst_v, input bit en, input bit rdy);
        bit    e_vld;
        bit    e_pop;
        beat_t b;
        @(posedge clk);
        #1;
        fifo_dout    = pend_dout ? pend_tile : tile_t'($urandom);
        pend_dout    = 1'b0;
        rst_n        = rst_v;
        fifo_pop_rdy = en && (fifo_q.size() > 0);
        out_ready    = rdy;
        #1;
        e_vld = rst_v && !fetch_wait && (exp_q.size() > 0);
        e_pop = rst_v && fifo_pop_rdy && !fetch_wait &&
                ((exp_q.size() == 0) || (e_vld && exp_q.size() == 1 && rdy));
        b = e_vld ? exp_q[0] : '0;
        chk("fifo_pop", 32'(fifo_pop), 32'(e_pop));
        chk("out_valid", 32'(out_valid), 32'(e_vld));
        chk("busy", 32'(busy), 32'(rst_v && (fetch_wait || exp_q.size() > 0)));
        chk("out_data", 32'(out_data), 32'(b.dat));
        chk("out_lane_vld", 32'(out_lane_vld), 32'(b.vld));
        chk("out_first", 32'(out_first), 32'(b.first));
        chk("out_last", 32'(out_last), 32'(b.last));
        if (!rst_v) begin
            exp_q.delete();
            fetch_wait = 1'b0;
        end else begin
            fetch_wait = 1'b0;
            if (e_vld && rdy) void'(exp_q.pop_front());
            if (e_pop) begin
                pend_tile  = fifo_q.pop_front();
                pend_dout  = 1'b1;
                fetch_wait = 1'b1;
                for (int k = 0; k < NB; k++) exp_q.push_back(make_beat(pend_tile, k));
            end
        end
    endtask

    function automatic tile_t tile4(input int a, input int b, input int c, input int d);
        tile_t t;
        t[0][0] = BITS'(a);
        t[0][1] = BITS'(b);
        t[1][0] = BITS'(c);
        t[1][1] = BITS'(d);
        return t;
    endfunction

    initial begin
        bit stall_pat [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};

        // Reset held with a non-empty FIFO: nothing may be popped.
        fifo_q.push_back(tile4(1, 2, 3, 4));
        repeat (3) step(0, 1, 1);

        // Single tile, ready always high.
        repeat (6) step(1, 1, 1);

        // Back-to-back tiles.
        fifo_q.push_back(tile4(8'h11, 8'h22, 8'h33, 8'h44));
        fifo_q.push_back(tile4(8'h55, 8'h66, 8'h77, 8'h88));
        repeat (11) step(1, 1, 1);

        // Backpressure for three cycles on beat 1.
        fifo_q.push_back(tile4(1, 2, 3, 4));
        for (int c = 0; c < 10; c++) step(1, 1, stall_pat[c]);

        // Empty FIFO for ten cycles, then it becomes non-empty.
        fifo_q.push_back(tile4(9, 8, 7, 6));
        repeat (10) step(1, 0, 1);
        repeat (6) step(1, 1, 1);

        // Reset during beat 1; the next queued tile must start from beat 0.
        fifo_q.push_back(tile4(8'ha1, 8'ha2, 8'ha3, 8'ha4));
        fifo_q.push_back(tile4(8'hb1, 8'hb2, 8'hb3, 8'hb4));
        repeat (3) step(1, 1, 1);
        step(0, 1, 1);
        repeat (8) step(1, 1, 1);

        // Random traffic, backpressure, FIFO availability and occasional reset.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4)
                fifo_q.push_back(tile_t'($urandom));
            step($urandom_range(0, 80) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 3) != 0);
        end
        fifo_q.delete();
        repeat (8) step(1, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
